// File: rtl/fp_mul_norm_round.sv
// rtl/fp_mul_norm_round.sv - post-multiply normalize/round stage, 2-stage valid/ready pipeline
module fp_mul_norm_round #(
  parameter int N = 12,
  parameter int E = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] in_prod,
  input  logic [E+1:0]   in_exp,
  input  logic           in_sign,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_sign,
  output logic [E-1:0]   out_exp,
  output logic [N-2:0]   out_frac,
  output logic           out_ovf,
  output logic           out_unf,
  output logic           out_inexact
);

  // Internal exponent is one bit wider than in_exp so +1 (normalize) and +1 (round carry)
  // can never wrap the signed range.
  localparam int XW = E + 3;

  // S1 (normalized) registers
  logic          s1_valid_q;
  logic          s1_zero_q,  s1_zero_d;
  logic          s1_sign_q,  s1_sign_d;
  logic          s1_g_q,     s1_g_d;
  logic          s1_s_q,     s1_s_d;
  logic [N-1:0]  s1_mant_q,  s1_mant_d;
  logic [XW-1:0] s1_exp_q,   s1_exp_d;

  // S2 (result) registers
  logic          out_valid_q;
  logic          out_sign_q, out_sign_d;
  logic [E-1:0]  out_exp_q,  out_exp_d;
  logic [N-2:0]  out_frac_q, out_frac_d;
  logic          out_ovf_q,  out_ovf_d;
  logic          out_unf_q,  out_unf_d;
  logic          out_inx_q,  out_inx_d;

  logic          s2_ready;
  logic          inc;
  logic [N:0]    mant_sum;
  logic [XW-1:0] rnd_exp;
  logic          ovf_c, unf_c;
  logic          hidden_unused;

  assign s2_ready = !out_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;

  // S1: pick the mantissa window according to whether the product overflowed into bit 2N-1
  always_comb begin
    s1_zero_d = (in_prod == '0);
    s1_sign_d = in_sign;
    if (in_prod[2*N-1]) begin
      s1_mant_d = in_prod[2*N-1:N];
      s1_g_d    = in_prod[N-1];
      s1_s_d    = |in_prod[N-2:0];
      s1_exp_d  = {in_exp[E+1], in_exp} + XW'(1);
    end else begin
      s1_mant_d = in_prod[2*N-2:N-1];
      s1_g_d    = in_prod[N-2];
      s1_s_d    = |in_prod[N-3:0];
      s1_exp_d  = {in_exp[E+1], in_exp};
    end
  end

  // S1 register: advances whenever the stage can accept, so a bubble is loaded when idle
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_g_q     <= 1'b0;
      s1_s_q     <= 1'b0;
      s1_mant_q  <= '0;
      s1_exp_q   <= '0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_zero_q <= s1_zero_d;
        s1_sign_q <= s1_sign_d;
        s1_g_q    <= s1_g_d;
        s1_s_q    <= s1_s_d;
        s1_mant_q <= s1_mant_d;
        s1_exp_q  <= s1_exp_d;
      end
    end
  end

  // S2: round to nearest even, renormalize on carry-out, then range check with zero first
  always_comb begin
    inc           = s1_g_q & (s1_mant_q[0] | s1_s_q);
    mant_sum      = {1'b0, s1_mant_q} + {{N{1'b0}}, inc};
    hidden_unused = mant_sum[N-1];
    rnd_exp       = s1_exp_q + {{(XW-1){1'b0}}, mant_sum[N]};
    ovf_c         = !rnd_exp[XW-1] && (rnd_exp >= XW'((1 << E) - 1));
    unf_c         = rnd_exp[XW-1] || (rnd_exp == '0);

    out_sign_d = s1_sign_q;
    out_exp_d  = '0;
    out_frac_d = '0;
    out_ovf_d  = 1'b0;
    out_unf_d  = 1'b0;
    out_inx_d  = 1'b0;
    if (s1_zero_q) begin
      out_exp_d = '0;
    end else if (ovf_c) begin
      out_ovf_d = 1'b1;
      out_inx_d = 1'b1;
      out_exp_d = '1;
    end else if (unf_c) begin
      out_unf_d = 1'b1;
      out_inx_d = 1'b1;
    end else begin
      out_exp_d  = rnd_exp[E-1:0];
      // On carry-out the mantissa becomes 1.000..0, so the fraction is all zeros
      out_frac_d = mant_sum[N] ? '0 : mant_sum[N-2:0];
      out_inx_d  = s1_g_q | s1_s_q;
    end
  end

  // S2 register: holds while the consumer stalls, only a valid S1 beat overwrites results
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_sign_q  <= 1'b0;
      out_exp_q   <= '0;
      out_frac_q  <= '0;
      out_ovf_q   <= 1'b0;
      out_unf_q   <= 1'b0;
      out_inx_q   <= 1'b0;
    end else if (s2_ready) begin
      out_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        out_sign_q <= out_sign_d;
        out_exp_q  <= out_exp_d;
        out_frac_q <= out_frac_d;
        out_ovf_q  <= out_ovf_d;
        out_unf_q  <= out_unf_d;
        out_inx_q  <= out_inx_d;
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_sign    = out_sign_q;
  assign out_exp     = out_exp_q;
  assign out_frac    = out_frac_q;
  assign out_ovf     = out_ovf_q;
  assign out_unf     = out_unf_q;
  assign out_inexact = out_inx_q;

endmodule

// File: tb/tb_fp_mul_norm_round.sv
// tb/tb_fp_mul_norm_round.sv - scoreboard bench for fp_mul_norm_round
module tb_fp_mul_norm_round;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [10:0] frac;
    logic        ovf;
    logic        unf;
    logic        inx;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_prod = '0;
  logic [9:0]  in_exp = '0;
  logic        in_sign = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sign;
  logic [7:0]  out_exp;
  logic [10:0] out_frac;
  logic        out_ovf;
  logic        out_unf;
  logic        out_inexact;

  int   checks = 0;
  int   failures = 0;
  bit   rand_mode = 1'b0;
  res_t q[$];

  fp_mul_norm_round #(.N(12), .E(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_prod(in_prod), .in_exp(in_exp), .in_sign(in_sign),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
  );

  always #5 clk = ~clk;

  // Bounds the whole run
  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit, got checks=%0d required finish", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  function automatic res_t mk(input logic s, input logic [7:0] e, input logic [10:0] f,
                              input logic o, input logic u, input logic x);
    res_t r;
    r.sign = s; r.exp = e; r.frac = f; r.ovf = o; r.unf = u; r.inx = x;
    return r;
  endfunction

  // Reference: treat the product as an integer, keep the top N bits, round by comparing the
  // discarded remainder against one half ulp.
  function automatic res_t model(input logic [23:0] p, input logic [9:0] e, input logic s);
    res_t r;
    int ex, sh, mant, rem, half, pi;
    r = '0;
    r.sign = s;
    if (p == 24'd0) return r;
    pi   = int'(p);
    ex   = int'($signed(e));
    sh   = p[23] ? 12 : 11;
    mant = pi >> sh;
    rem  = pi - (mant << sh);
    half = 1 << (sh - 1);
    if (rem > half || (rem == half && (mant % 2) == 1)) mant++;
    ex = ex + sh - 11;
    if (mant == 4096) begin
      mant = 2048;
      ex++;
    end
    r.inx = (rem != 0);
    if (ex >= 255) begin
      r.ovf = 1'b1; r.inx = 1'b1; r.exp = 8'hFF;
    end else if (ex <= 0) begin
      r.unf = 1'b1; r.inx = 1'b1;
    end else begin
      r.exp  = 8'(ex);
      r.frac = 11'(mant % 2048);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_mode) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Presents one beat and pushes its expected result at the accepting edge
  task automatic send(input logic [23:0] p, input logic [9:0] e, input logic s, input res_t exp_r);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_prod = p; in_exp = e; in_sign = s;
    for (int c = 0; c < 200 && !done; c++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(exp_r);
        done = 1'b1;
      end
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: any presented result must match the queue head; held results are rechecked each
  // cycle, so a value changing under stall is caught too
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_out", 32'd1, 32'd0);
      end else begin
        chk("result", 32'({out_sign, out_exp, out_frac, out_ovf, out_unf, out_inexact}),
            32'(q[0]));
        if (out_ready) void'(q.pop_front());
      end
    end
  end

  initial begin
    logic [23:0] p;
    logic [9:0]  e;
    logic        s;
    int          ev;
    int          pick;
    int          lim;

    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_in_ready", 32'(in_ready), 32'd1);
    chk("reset_out_regs", 32'({out_sign, out_exp, out_frac, out_ovf, out_unf, out_inexact}), 32'd0);
    tick();

    // 1.5*1.5 with latency check
    send(24'h900000, 10'd127, 1'b0, mk(1'b0, 8'd128, 11'h100, 1'b0, 1'b0, 1'b0));
    @(negedge clk);
    chk("latency_edge1", 32'(out_valid), 32'd0);
    tick();
    @(negedge clk);
    chk("latency_edge2", 32'(out_valid), 32'd1);
    tick();

    // Ties, round carry, overflow, underflow, signed zero
    send(24'h400400, 10'd50, 1'b0, mk(1'b0, 8'd50, 11'h000, 1'b0, 1'b0, 1'b1));
    send(24'h400C00, 10'd50, 1'b0, mk(1'b0, 8'd50, 11'h002, 1'b0, 1'b0, 1'b1));
    send(24'h7FFC00, 10'd100, 1'b0, mk(1'b0, 8'd101, 11'h000, 1'b0, 1'b0, 1'b1));
    send(24'h900000, 10'd254, 1'b1, mk(1'b1, 8'hFF, 11'h000, 1'b1, 1'b0, 1'b1));
    send(24'h400000, 10'd0, 1'b0, mk(1'b0, 8'h00, 11'h000, 1'b0, 1'b1, 1'b1));
    send(24'h000000, 10'd77, 1'b1, mk(1'b1, 8'h00, 11'h000, 1'b0, 1'b0, 1'b0));
    repeat (4) tick();

    // Stall: two beats fill the pipe, third is held at the input
    out_ready = 1'b0;
    send(24'hA00000, 10'd10, 1'b0, mk(1'b0, 8'd11, 11'h200, 1'b0, 1'b0, 1'b0));
    send(24'h600000, 10'd20, 1'b1, mk(1'b1, 8'd20, 11'h400, 1'b0, 1'b0, 1'b0));
    in_valid = 1'b1; in_prod = 24'hC00000; in_exp = 10'd30; in_sign = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      tick();
    end
    out_ready = 1'b1;
    send(24'hC00000, 10'd30, 1'b0, mk(1'b0, 8'd31, 11'h400, 1'b0, 1'b0, 1'b0));
    repeat (4) tick();
    chk("stall_drained", 32'(q.size()), 32'd0);

    // Randomized traffic with backpressure, biased toward range edges and rounding ties
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      pick = int'($urandom_range(0, 15));
      if (pick == 0) p = 24'd0;
      else p = 24'($urandom_range(32'h400000, 32'hFFFFFF));
      if (pick == 1 || pick == 2) begin
        if (p[23]) p[11:0] = 12'h800;
        else p[10:0] = 11'h400;
      end
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0: ev = 253;
          1: ev = 254;
          2: ev = 255;
          3: ev = -1;
          4: ev = 0;
          default: ev = 1;
        endcase
      end else begin
        ev = int'($urandom_range(0, 765)) - 256;
      end
      e = 10'(ev);
      s = 1'($urandom_range(0, 1));
      send(p, e, s, model(p, e, s));
      lim = int'($urandom_range(0, 2));
      for (int g = 0; g < lim; g++) tick();
    end
    rand_mode = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 100 && q.size() != 0; c++) tick();
    chk("random_drained", 32'(q.size()), 32'd0);

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(24'h900000, 10'd60, 1'b0, mk(1'b0, 8'd61, 11'h100, 1'b0, 1'b0, 1'b0));
    send(24'h900000, 10'd70, 1'b0, mk(1'b0, 8'd71, 11'h100, 1'b0, 1'b0, 1'b0));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      @(negedge clk);
      chk("rst_no_emit", 32'(out_valid), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
